// File: rtl/letter_sched_pkg.sv
// rtl/letter_sched_pkg.sv - shared types and helpers for the letter transmit scheduler
package letter_sched_pkg;

    localparam int LETTER_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } sched_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/letter_tx_scheduler_if.sv
// rtl/letter_tx_scheduler_if.sv - encoder, BRAM and transmitter signals of the letter scheduler
interface letter_tx_scheduler_if #(
    parameter int DATA_W = 5,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
);
    logic              flush_in;
    logic              enc_valid_in;
    logic [DATA_W-1:0] enc_data_in;
    logic              wr_en_out;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [DATA_W-1:0] wr_data_out;
    logic [ADDR_W-1:0] rd_addr_out;
    logic [DATA_W-1:0] rd_data_in;
    logic              tx_busy_in;
    logic              tx_valid_out;
    logic [DATA_W-1:0] tx_data_out;
    logic [CNT_W-1:0]  count_out;
    logic              empty_out;
    logic              full_out;
    logic              overflow_out;

    modport master (
        input  flush_in, enc_valid_in, enc_data_in, rd_data_in, tx_busy_in,
        output wr_en_out, wr_addr_out, wr_data_out, rd_addr_out,
               tx_valid_out, tx_data_out, count_out, empty_out, full_out, overflow_out
    );

    modport slave (
        output flush_in, enc_valid_in, enc_data_in, rd_data_in, tx_busy_in,
        input  wr_en_out, wr_addr_out, wr_data_out, rd_addr_out,
               tx_valid_out, tx_data_out, count_out, empty_out, full_out, overflow_out
    );
endinterface

// File: rtl/sched_timer.sv
// rtl/sched_timer.sv - loadable down-counter, done while the count sits at zero
module sched_timer #(
    parameter int W = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/letter_tx_scheduler.sv
// rtl/letter_tx_scheduler.sv - circular letter buffer control and paced hand-off to the IR transmitter
module letter_tx_scheduler
    import letter_sched_pkg::*;
#(
    parameter int DATA_W       = LETTER_W,
    parameter int DEPTH        = 1000,
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 2,
    parameter int GAP_CYCLES   = 100000,
    parameter int BUSY_WAIT    = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    letter_tx_scheduler_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int T_MAX = max3(max3(READ_LATENCY, GAP_CYCLES, BUSY_WAIT), 1, 1);
    localparam int T_W   = $clog2(T_MAX + 1);

    localparam logic [T_W-1:0]    RD_LOAD  = T_W'(READ_LATENCY - 1);
    localparam logic [T_W-1:0]    BW_LOAD  = T_W'(BUSY_WAIT - 1);
    localparam logic [T_W-1:0]    GAP_LOAD = T_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    sched_state_t      state;
    logic              prev_valid;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              tx_valid_q;
    logic [DATA_W-1:0] tx_data;

    logic              enc_edge;
    logic              full;
    logic              start;
    logic              issue_fire;
    logic              t_load;
    logic [T_W-1:0]    t_val;
    logic              t_done;

    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + ADDR_W'(1);
    endfunction

    assign enc_edge   = bus.enc_valid_in & ~prev_valid;
    assign full       = (count == CNT_FULL);
    // Flush blocks the start so a READ can never begin on a count being cleared.
    assign start      = (state == IDLE) && (count != '0) && !bus.tx_busy_in && !bus.flush_in;
    assign issue_fire = (state == ISSUE) && !bus.flush_in;

    always_comb begin
        t_load = 1'b0;
        t_val  = RD_LOAD;
        case (state)
            IDLE: begin
                t_load = start;
                t_val  = RD_LOAD;
            end
            ISSUE: begin
                t_load = 1'b1;
                t_val  = BW_LOAD;
            end
            WAIT_BUSY: begin
                t_load = !bus.tx_busy_in && t_done;
                t_val  = GAP_LOAD;
            end
            WAIT_DONE: begin
                t_load = !bus.tx_busy_in;
                t_val  = GAP_LOAD;
            end
            default: ;
        endcase
    end

    sched_timer #(.W(T_W)) u_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .load       (t_load),
        .load_value (t_val),
        .done       (t_done)
    );

    // A write is committed on the edge that ends its wr_en cycle, together with the BRAM write.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            prev_valid <= 1'b0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            prev_valid <= bus.enc_valid_in;
            wr_en      <= enc_edge && !full && !bus.flush_in;
            if (enc_edge && !full && !bus.flush_in) begin
                wr_data <= bus.enc_data_in;
            end
            if (bus.flush_in) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= ptr_next(wr_ptr);
                end
                if (issue_fire) begin
                    rd_ptr <= ptr_next(rd_ptr);
                end
                count <= count + CNT_W'(wr_en) - CNT_W'(issue_fire);
                if (enc_edge && full) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data    <= '0;
        end else begin
            tx_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (bus.flush_in) begin
                        state <= IDLE;
                    end else if (t_done) begin
                        tx_data    <= bus.rd_data_in;
                        tx_valid_q <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= bus.flush_in ? IDLE : WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy_in) begin
                        state <= WAIT_DONE;
                    end else if (t_done) begin
                        state <= GAP;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy_in) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (t_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // rd_ptr is stable from the IDLE decision through READ, so the BRAM sees the address a cycle early.
    assign bus.rd_addr_out  = rd_ptr;
    assign bus.wr_en_out    = wr_en;
    assign bus.wr_addr_out  = wr_ptr;
    assign bus.wr_data_out  = wr_data;
    assign bus.tx_valid_out = tx_valid_q & ~bus.flush_in;
    assign bus.tx_data_out  = tx_data;
    assign bus.count_out    = count;
    assign bus.empty_out    = (count == '0);
    assign bus.full_out     = full;
    assign bus.overflow_out = overflow;
endmodule
